// File: rtl/stream_rr_arbiter.sv
// Packet-level round-robin arbiter and mux. It shares one valid/ready/last stream sink between N_SRC sources.
// A grant is held from the packet's first beat until the granted source's last beat is accepted.
module stream_rr_arbiter #(
    parameter int N_SRC  = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_SRC-1:0]        s_valid,
    input  logic [N_SRC-1:0]        s_last,
    input  logic [N_SRC*DATA_W-1:0] s_data,
    output logic [N_SRC-1:0]        s_ready,
    output logic                    m_valid,
    output logic                    m_last,
    output logic [DATA_W-1:0]       m_data,
    input  logic                    m_ready,
    output logic [N_SRC-1:0]        grant,
    output logic                    busy,
    output logic [CNT_W-1:0]        pkt_cnt
);
    localparam int               IDX_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SRC - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  g_q, g_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;

    logic [DATA_W-1:0] src_data [N_SRC];
    logic              any_req;
    logic [IDX_W-1:0]  pick_idx;
    logic              pkt_done;

    for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
        assign src_data[i] = s_data[i*DATA_W +: DATA_W];
    end

    // Rotating priority scan. Walking downward and overwriting leaves the
    // lowest offset from ptr_q as the winner.
    always_comb begin
        int               idx;
        logic [IDX_W-1:0] idx_w;
        // NOTE: every signal assigned in a combinational block gets a default first, so no path can infer a latch.
        any_req  = 1'b0;
        pick_idx = '0;
        idx      = 0;
        idx_w    = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_SRC) begin
                idx = idx - N_SRC;
            end
            idx_w = IDX_W'(idx);
            if (s_valid[idx_w]) begin
                any_req  = 1'b1;
                pick_idx = idx_w;
            end
        end
    end

    assign pkt_done = (state_q == BUSY) && s_valid[g_q] && s_last[g_q] && m_ready;

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            g_q       <= '0;
            ptr_q     <= '0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            ptr_q     <= ptr_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        ptr_d     = ptr_q;
        pkt_cnt_d = pkt_cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    g_d     = pick_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (pkt_done) begin
                    state_d   = IDLE;
                    pkt_cnt_d = pkt_cnt_q + 1'b1;
                    ptr_d     = (g_q == LAST_IDX) ? '0 : g_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The granted source is passed straight through to the sink with no added latency.
    always_comb begin
        s_ready = '0;
        grant   = '0;
        busy    = 1'b0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_data  = '0;
        if (state_q == BUSY) begin
            busy         = 1'b1;
            grant[g_q]   = 1'b1;
            s_ready[g_q] = m_ready;
            m_valid      = s_valid[g_q];
            m_last       = s_last[g_q];
            m_data       = src_data[g_q];
        end
    end

    assign pkt_cnt = pkt_cnt_q;

endmodule
